// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - redirect select encodings driven by decode on pc_src
//   - fetch FSM state encoding
//   - default NOP word injected into IF/ID on flush/reset
//   - word-address PC increment helper
package fetch_pkg;

  localparam logic [1:0] PC_SRC_NONE   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // IDLE : first cycle after reset, launches at pc
  // WAIT : a live request is outstanding
  // HOLD : a response is parked while downstream is held
  // DRAIN: a stale request (pre-redirect) is outstanding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

  // Word-addressed increment; wraps modulo 2^32 silently.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_reg.sv
// fetch_reg: generic register with enable and synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (loads CLR_VAL)
//   en         : load d when high
//   clr        : synchronous clear to CLR_VAL, wins over en
//   d / q      : data in / registered data out
module fetch_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with clear taking priority over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CLR_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_target_sel.sv
// pc_target_sel: 4:1 redirect target mux.
//   pc_src            : 00 none, 01 branch, 10 jump, 11 jr
//   branch, jump, jr  : candidate targets from decode
//   target            : selected redirect target (don't-care when pc_src=00)
module pc_target_sel
  import fetch_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [31:0] jump,
  input  logic [31:0] jr,
  output logic [31:0] target
);

  // Target selection on the redirect code.
  always_comb begin
    target = 32'h0000_0000;
    case (pc_src)
      PC_SRC_BRANCH: target = branch;
      PC_SRC_JUMP:   target = jump;
      PC_SRC_JR:     target = jr;
      default:       target = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single-outstanding imem handshake
// and the IF/ID buffer.
//   clk, clear        : clock; asynchronous active-low reset
//   stall, turn_off   : hold PC and IF/ID (identical meaning)
//   pc_src, branch, jump, jr : redirect select and targets from decode
//   kill              : flush IF/ID without a PC change
//   imem_req/addr     : combinational launch strobe and address
//   imem_rdata/valid  : returned instruction and its strobe
//   inst_buff_data, pc_buff_tun, pc_link, inst_valid : IF/ID contents
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        stall,
  input  logic        turn_off,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [31:0] jump,
  input  logic [31:0] jr,
  input  logic        kill,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] inst_buff_data,
  output logic [31:0] pc_buff_tun,
  output logic [31:0] pc_link,
  output logic        inst_valid
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  buf_data_r, buf_pc_r;
  logic [31:0]  target_s, addr_s, load_data_s, load_pc_s;
  logic         hold_s, redirect_s, req_s, load_s, flush_s, park_s;
  logic [32:0]  ifid_inst_q_s;
  logic [63:0]  ifid_pc_q_s;

  assign hold_s     = stall | turn_off;
  assign redirect_s = (pc_src != PC_SRC_NONE);

  pc_target_sel u_target_sel (
    .pc_src (pc_src),
    .branch (branch),
    .jump   (jump),
    .jr     (jr),
    .target (target_s)
  );

  // Next-state, PC update, launch and IF/ID load/flush decisions.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    req_s       = 1'b0;
    addr_s      = pc_r;
    load_s      = 1'b0;
    flush_s     = kill;
    park_s      = 1'b0;
    load_data_s = imem_rdata;
    load_pc_s   = pc_r;
    case (state_r)
      ST_IDLE: begin
        req_s       = 1'b1;
        state_nxt_s = ST_WAIT;
        if (redirect_s) begin
          pc_nxt_s = target_s;
          addr_s   = target_s;
          flush_s  = 1'b1;
        end else begin
          addr_s = pc_r;
        end
      end
      ST_WAIT: begin
        if (redirect_s) begin
          pc_nxt_s = target_s;
          flush_s  = 1'b1;
          if (imem_valid) begin
            // Response belongs to the old path: drop it, relaunch now.
            req_s  = 1'b1;
            addr_s = target_s;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else if (imem_valid) begin
          if (hold_s) begin
            park_s      = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            load_s   = 1'b1;
            pc_nxt_s = pc_inc(pc_r);
            req_s    = 1'b1;
            addr_s   = pc_inc(pc_r);
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_s) begin
          pc_nxt_s    = target_s;
          flush_s     = 1'b1;
          req_s       = 1'b1;
          addr_s      = target_s;
          state_nxt_s = ST_WAIT;
        end else if (!hold_s) begin
          load_s      = 1'b1;
          load_data_s = buf_data_r;
          load_pc_s   = buf_pc_r;
          pc_nxt_s    = pc_inc(buf_pc_r);
          req_s       = 1'b1;
          addr_s      = pc_inc(buf_pc_r);
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (imem_valid) begin
          // Stale data is discarded; the pending path starts now.
          req_s       = 1'b1;
          state_nxt_s = ST_WAIT;
          if (redirect_s) begin
            pc_nxt_s = target_s;
            addr_s   = target_s;
          end else begin
            addr_s = pc_r;
          end
        end else if (redirect_s) begin
          pc_nxt_s = target_s;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // No launch may be seen while reset is asserted.
  assign imem_req  = req_s & clear;
  assign imem_addr = addr_s;

  // FSM state and program counter.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Hold buffer: captures a response that arrives while downstream is held.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      buf_data_r <= 32'h0000_0000;
      buf_pc_r   <= 32'h0000_0000;
    end else if (park_s) begin
      buf_data_r <= imem_rdata;
      buf_pc_r   <= pc_r;
    end
  end

  // IF/ID instruction + valid: flushed to NOP/invalid, flush beats load.
  fetch_reg #(
    .WIDTH   (33),
    .CLR_VAL ({NOP_INST, 1'b0})
  ) u_ifid_inst (
    .clk   (clk),
    .rst_n (clear),
    .en    (load_s | flush_s),
    .clr   (flush_s),
    .d     ({load_data_s, 1'b1}),
    .q     (ifid_inst_q_s)
  );

  // IF/ID PC pair: held across a flush, only updated by a real load.
  fetch_reg #(
    .WIDTH   (64),
    .CLR_VAL (64'h0)
  ) u_ifid_pc (
    .clk   (clk),
    .rst_n (clear),
    .en    (load_s & ~flush_s),
    .clr   (1'b0),
    .d     ({load_pc_s, pc_inc(load_pc_s)}),
    .q     (ifid_pc_q_s)
  );

  assign inst_buff_data = ifid_inst_q_s[32:1];
  assign inst_valid     = ifid_inst_q_s[0];
  assign pc_buff_tun    = ifid_pc_q_s[63:32];
  assign pc_link        = ifid_pc_q_s[31:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized bench for fetch_stage with an
// in-bench memory (programmable latency) and a behavioural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        clear, stall, turn_off, kill;
  logic [1:0]  pc_src;
  logic [31:0] branch, jump, jr;
  logic        imem_req, imem_valid, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst_buff_data, pc_buff_tun, pc_link;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .clear          (clear),
    .stall          (stall),
    .turn_off       (turn_off),
    .pc_src         (pc_src),
    .branch         (branch),
    .jump           (jump),
    .jr             (jr),
    .kill           (kill),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .inst_buff_data (inst_buff_data),
    .pc_buff_tun    (pc_buff_tun),
    .pc_link        (pc_link),
    .inst_valid     (inst_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: fetch bookkeeping and expected IF/ID.
  logic [31:0] m_pc, m_park_data, m_data, m_pcb, m_link;
  logic        m_started, m_out, m_stale, m_park, m_vld;
  // Memory model: one pending request with a countdown.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic        g_req;
  logic [31:0] g_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0;
    m_park = 1'b0; m_park_data = 32'h0;
    m_data = 32'h0; m_pcb = 32'h0; m_link = 32'h0; m_vld = 1'b0;
    mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, check registered outputs and the launch
  // against the model, then advance model and memory past the next edge.
  task automatic run_cycle(input logic st, input logic to, input logic [1:0] src,
                           input logic [31:0] br, input logic [31:0] jp,
                           input logic [31:0] jv, input logic kl, input int lat,
                           output logic a_req, output logic [31:0] a_addr);
    logic hold, redir, flush, load, e_req;
    logic [31:0] tgt, e_addr, ld_data, ld_pc;
    @(negedge clk);
    stall = st; turn_off = to; pc_src = src;
    branch = br; jump = jp; jr = jv; kill = kl;
    if (mem_pend && mem_cnt == 1) begin
      imem_valid = 1'b1; imem_rdata = mem_word(mem_addr);
    end else begin
      imem_valid = 1'b0; imem_rdata = $urandom;
    end
    #2;
    a_req = imem_req; a_addr = imem_addr;
    check("inst_buff_data", inst_buff_data, m_data);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_vld});
    check("pc_buff_tun", pc_buff_tun, m_pcb);
    check("pc_link", pc_link, m_link);

    hold = st | to;
    redir = (src != 2'd0);
    tgt = (src == 2'd1) ? br : (src == 2'd2) ? jp : jv;
    e_req = 1'b0; e_addr = 32'h0; load = 1'b0; flush = kl;
    ld_data = 32'h0; ld_pc = 32'h0;
    if (!m_started) begin
      m_started = 1'b1; m_out = 1'b1; m_stale = 1'b0;
      e_req = 1'b1; e_addr = m_pc;
    end else if (m_park) begin
      if (redir) begin
        flush = 1'b1; m_pc = tgt; e_req = 1'b1; e_addr = tgt;
        m_park = 1'b0; m_out = 1'b1;
      end else if (!hold) begin
        load = 1'b1; ld_data = m_park_data; ld_pc = m_pc;
        m_pc = m_pc + 32'd1; e_req = 1'b1; e_addr = m_pc;
        m_park = 1'b0; m_out = 1'b1;
      end
    end else if (m_out && m_stale) begin
      if (imem_valid) begin
        if (redir) m_pc = tgt;
        e_req = 1'b1; e_addr = m_pc; m_stale = 1'b0;
      end else if (redir) begin
        m_pc = tgt;
      end
    end else if (m_out) begin
      if (redir) begin
        flush = 1'b1; m_pc = tgt;
        if (imem_valid) begin
          e_req = 1'b1; e_addr = tgt;
        end else begin
          m_stale = 1'b1;
        end
      end else if (imem_valid) begin
        if (hold) begin
          m_park = 1'b1; m_park_data = imem_rdata; m_out = 1'b0;
        end else begin
          load = 1'b1; ld_data = imem_rdata; ld_pc = m_pc;
          m_pc = m_pc + 32'd1; e_req = 1'b1; e_addr = m_pc;
        end
      end
    end
    check("imem_req", {31'd0, a_req}, {31'd0, e_req});
    if (e_req) check("imem_addr", a_addr, e_addr);

    if (imem_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (e_req) begin
      mem_pend = 1'b1; mem_addr = e_addr; mem_cnt = lat;
    end

    if (flush) begin
      m_data = 32'h0; m_vld = 1'b0;
    end else if (load) begin
      m_data = ld_data; m_pcb = ld_pc; m_link = ld_pc + 32'd1; m_vld = 1'b1;
    end
  endtask

  task automatic go(input logic st, input logic [1:0] src, input logic [31:0] tgt, input int lat);
    run_cycle(st, 1'b0, src,
              (src == 2'd1) ? tgt : 32'hDEAD_0001,
              (src == 2'd2) ? tgt : 32'hDEAD_0002,
              (src == 2'd3) ? tgt : 32'hDEAD_0003,
              1'b0, lat, g_req, g_addr);
  endtask

  initial begin
    logic st, to, kl;
    logic [1:0] src;
    logic [31:0] br, jp, jv;
    int lat;
    clear = 1'b0; stall = 1'b0; turn_off = 1'b0; kill = 1'b0;
    pc_src = 2'd0; branch = 32'h0; jump = 32'h0; jr = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      #2;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_data", inst_buff_data, 32'h0);
    end
    @(posedge clk); #1; clear = 1'b1;
    go(1'b0, 2'd0, 32'h0, 1);
    check("t1_req", {31'd0, g_req}, 32'd1);
    check("t1_addr", g_addr, 32'h0);

    // Streaming with a latency-1 memory.
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 2'd0, 32'h0, 1);
      at_edge();
      check("t2_pcb", pc_buff_tun, i);
      check("t2_data", inst_buff_data, 32'h1000_0000 + i);
      check("t2_link", pc_link, i + 1);
    end

    // Stall for three cycles as the addr-5 response arrives.
    go(1'b0, 2'd0, 32'h0, 1);
    go(1'b1, 2'd0, 32'h0, 1);
    check("t3_noreq", {31'd0, g_req}, 32'd0);
    at_edge();
    check("t3_frozen", pc_buff_tun, 32'd4);
    go(1'b1, 2'd0, 32'h0, 1);
    go(1'b1, 2'd0, 32'h0, 1);
    go(1'b0, 2'd0, 32'h0, 1);
    check("t3_req", {31'd0, g_req}, 32'd1);
    check("t3_addr", g_addr, 32'd6);
    at_edge();
    check("t3_pcb", pc_buff_tun, 32'd5);

    // Latency-3 request at addr 8, branch one cycle later.
    go(1'b0, 2'd0, 32'h0, 1);
    go(1'b0, 2'd0, 32'h0, 3);
    check("t4_addr8", g_addr, 32'd8);
    go(1'b0, 2'd1, 32'h40, 1);
    at_edge();
    check("t4_flush", {31'd0, inst_valid}, 32'd0);
    go(1'b0, 2'd0, 32'h0, 1);
    check("t4_drain_noreq", {31'd0, g_req}, 32'd0);
    go(1'b0, 2'd0, 32'h0, 1);
    check("t4_req", {31'd0, g_req}, 32'd1);
    check("t4_addr", g_addr, 32'h40);
    at_edge();
    check("t4_stale_dropped", {31'd0, inst_valid}, 32'd0);
    go(1'b0, 2'd0, 32'h0, 1);
    at_edge();
    check("t4_pcb", pc_buff_tun, 32'h40);
    check("t4_data", inst_buff_data, 32'h1000_0040);

    // jr coincident with a response, without and with stall.
    go(1'b0, 2'd3, 32'h80, 1);
    check("t5_addr", g_addr, 32'h80);
    at_edge();
    check("t5_flush", {31'd0, inst_valid}, 32'd0);
    go(1'b1, 2'd3, 32'h80, 1);
    check("t5s_req", {31'd0, g_req}, 32'd1);
    check("t5s_addr", g_addr, 32'h80);
    at_edge();
    check("t5s_flush", {31'd0, inst_valid}, 32'd0);
    go(1'b0, 2'd0, 32'h0, 1);
    at_edge();
    check("t5_pcb", pc_buff_tun, 32'h80);

    // PC wrap from the top of the address space.
    go(1'b0, 2'd2, 32'hFFFF_FFFF, 1);
    go(1'b0, 2'd0, 32'h0, 1);
    check("wrap_addr", g_addr, 32'h0);
    at_edge();
    check("wrap_pcb", pc_buff_tun, 32'hFFFF_FFFF);
    check("wrap_link", pc_link, 32'h0);

    // Park the addr-1 response, then reset asynchronously mid-HOLD.
    go(1'b0, 2'd0, 32'h0, 1);
    go(1'b1, 2'd0, 32'h0, 1);
    at_edge();
    #2 clear = 1'b0;
    #1;
    check("t6_data", inst_buff_data, 32'h0);
    check("t6_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_pcb", pc_buff_tun, 32'h0);
    check("t6_link", pc_link, 32'h0);
    check("t6_req", {31'd0, imem_req}, 32'd0);
    model_reset();
    stall = 1'b0; imem_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      check("t6_req_rst", {31'd0, imem_req}, 32'd0);
    end
    @(posedge clk); #1; clear = 1'b1;
    go(1'b0, 2'd0, 32'h0, 1);
    check("t6_restart_addr", g_addr, 32'h0);
    go(1'b0, 2'd0, 32'h0, 1);
    at_edge();
    check("t6_restart_pcb", pc_buff_tun, 32'h0);
    check("t6_restart_data", inst_buff_data, 32'h1000_0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      to  = ($urandom_range(0, 7) == 0);
      src = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (!m_started) src = 2'd0;
      br  = $urandom;
      jp  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      jv  = $urandom;
      kl  = ($urandom_range(0, 9) == 0);
      lat = $urandom_range(1, 3);
      run_cycle(st, to, src, br, jp, jv, kl, lat, g_req, g_addr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
